// File: rtl/as2650_bus_pkg.sv
// Purpose: shared FSM state type and timeout constant for the AS2650 bus unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package as2650_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        ACCESS,
        HOLD
    } bus_state_t;

    // Maximum number of pad_wait extension cycles before a forced HOLD.
    localparam int TIMEOUT_LIMIT = 256;
    localparam int EXT_W         = $clog2(TIMEOUT_LIMIT + 1);

endpackage

// File: rtl/as2650_wait_ctr.sv
// Purpose: ACCESS-phase wait counter (load/decrement) plus pad_wait timeout counter.
// Latency: done is combinational on the final ACCESS cycle; counters update on clk.
// Backpressure: ext_req (pad_wait) holds done low on the final cycle; with
//   AS2650_BUS_TIMEOUT_EN the extension is capped at TIMEOUT_LIMIT cycles.
// Ports: load/load_val latch the wait count; active marks ACCESS; done/expired
//   report the exit cycle and whether it was forced by the timeout.
module as2650_wait_ctr
    import as2650_bus_pkg::*;
#(
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              active,
    input  logic              ext_req,
    output logic              done,
    output logic              expired
);

    logic [WAIT_W-1:0] cnt;
    logic              last;

    // Final programmed cycle of ACCESS: only from here can pad_wait extend.
    assign last = active && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (active && (cnt != '0)) begin
            cnt <= cnt - WAIT_W'(1);
        end
    end

`ifdef AS2650_BUS_TIMEOUT_EN
    logic [EXT_W-1:0] ext_cnt;

    // ext_cnt counts final cycles already extended; once it reaches the
    // limit the next final cycle exits regardless of pad_wait.
    assign expired = last && (ext_cnt == EXT_W'(TIMEOUT_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_cnt <= '0;
        end else if (load) begin
            ext_cnt <= '0;
        end else if (last && ext_req && !expired) begin
            ext_cnt <= ext_cnt + EXT_W'(1);
        end
    end
`else
    assign expired = 1'b0;
`endif

    assign done = last && (!ext_req || expired);

endmodule

// File: rtl/as2650_bus_unit.sv
// Purpose: AS2650 external bus sequencer (multiplexed AD bus, ALE, RD/WR strobes).
// Latency: zero-wait cycle = ADDR, ACCESS, HOLD; core_ready 3 cycles after core_req.
// Backpressure: cfg_wait adds ACCESS cycles, pad_wait extends the last one;
//   optional macro AS2650_BUS_TIMEOUT_EN caps the extension and sets timeout.
// Ports: core_* is the core-side request/response, pad_* the pin side,
//   cfg_wait the per-cycle wait-state count, timeout the sticky error flag.
module as2650_bus_unit
    import as2650_bus_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int WAIT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     core_req,
    input  logic                     core_we,
    input  logic                     core_mio,
    input  logic [ADDR_W-1:0]        core_adr,
    input  logic [DATA_W-1:0]        core_wdata,
    output logic [DATA_W-1:0]        core_rdata,
    output logic                     core_ready,
    input  logic [WAIT_W-1:0]        cfg_wait,
    input  logic [DATA_W-1:0]        pad_ad_in,
    output logic [DATA_W-1:0]        pad_ad_out,
    output logic                     pad_ad_oeb,
    output logic [ADDR_W-DATA_W-1:0] pad_adr_hi,
    output logic                     pad_ale,
    output logic                     pad_rd_n,
    output logic                     pad_wr_n,
    output logic                     pad_mio,
    input  logic                     pad_wait,
    output logic                     timeout
);

    bus_state_t        state, state_nxt;
    logic              we_q;
    logic              mio_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              start;
    logic              in_access;
    logic              done;
    logic              expired;

    assign start     = (state == IDLE) && core_req;
    assign in_access = (state == ACCESS);

    as2650_wait_ctr #(
        .WAIT_W (WAIT_W)
    ) u_wait_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .load_val (cfg_wait),
        .active   (in_access),
        .ext_req  (pad_wait),
        .done     (done),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request fields are latched once in IDLE so mid-cycle core changes
    // (including cfg_wait) cannot disturb a cycle in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            mio_q      <= 1'b0;
            adr_q      <= '0;
            wdata_q    <= '0;
            core_rdata <= '0;
        end else begin
            if (start) begin
                we_q    <= core_we;
                mio_q   <= core_mio;
                adr_q   <= core_adr;
                wdata_q <= core_wdata;
            end
            if (in_access && done && !we_q) begin
                core_rdata <= expired ? '1 : pad_ad_in;
            end
        end
    end

`ifdef AS2650_BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else if (expired) begin
            timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign pad_adr_hi = adr_q[ADDR_W-1:DATA_W];
    assign pad_mio    = mio_q;

    // Pad strobes decode straight from state so an asynchronous reset
    // releases them in the same cycle.
    always_comb begin
        state_nxt  = state;
        pad_ale    = 1'b0;
        pad_ad_out = '0;
        pad_ad_oeb = 1'b1;
        pad_rd_n   = 1'b1;
        pad_wr_n   = 1'b1;
        core_ready = 1'b0;
        case (state)
            IDLE: begin
                if (core_req) state_nxt = ADDR;
            end
            ADDR: begin
                pad_ale    = 1'b1;
                pad_ad_out = adr_q[DATA_W-1:0];
                pad_ad_oeb = 1'b0;
                state_nxt  = ACCESS;
            end
            ACCESS: begin
                if (we_q) begin
                    pad_wr_n   = 1'b0;
                    pad_ad_out = wdata_q;
                    pad_ad_oeb = 1'b0;
                end else begin
                    pad_rd_n   = 1'b0;
                end
                if (done) state_nxt = HOLD;
            end
            HOLD: begin
                core_ready = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
